mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Parameters
REQ-001 The block SHALL provide parameter DATA_WIDTH, default 32, meaning the data bus width; legal values are 32 and 64.
REQ-002 The block SHALL provide parameter META_WIDTH, default 48, meaning the width of the opaque pass-through bundle (rd, RegWrite, ResultSrc, pc_plus_4).
REQ-003 The block SHALL provide parameter MAX_WAIT, default 15, meaning the maximum number of cycles spent in WAIT_RSP before a timeout fault.

Interface (name  direction  width  meaning)
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: clk  in  1  clock; reset  in  1  asynchronous active-high reset.
REQ-005 Upstream ports SHALL be: in_valid in 1; in_ready out 1; in_addr in 32 (ALU result); in_wdata in DATA_WIDTH; in_funct3 in 3; in_mem_read in 1; in_mem_write in 1; in_meta in META_WIDTH.
REQ-006 Memory ports SHALL be: mem_req_valid out 1; mem_req_ready in 1; mem_req_we out 1; mem_req_addr out 32 (aligned to DATA_WIDTH/8 bytes); mem_req_wdata out DATA_WIDTH; mem_req_be out DATA_WIDTH/8; mem_rsp_valid in 1; mem_rsp_rdata in DATA_WIDTH.
REQ-007 Downstream ports SHALL be: out_valid out 1; out_ready in 1; out_load_data out DATA_WIDTH; out_alu_result out 32; out_meta out META_WIDTH; out_fault out 2 (00 none, 01 misaligned, 10 timeout, 11 illegal funct3).

Function
REQ-008 The FSM SHALL have the states IDLE, REQ, WAIT_RSP and HOLD.
REQ-009 in_ready SHALL be high only in IDLE; an operation is accepted on a cycle where in_valid and in_ready are both high.
REQ-010 In IDLE, an accepted operation with neither read nor write, or one that is faulting, SHALL be registered to the outputs and go to HOLD with out_valid=1 on the next cycle (1-cycle latency); no memory request is issued.
REQ-011 In IDLE, an accepted valid load or store SHALL latch all inputs and go to REQ.
REQ-012 Misalignment SHALL be defined as follows: a halfword is misaligned when addr[0]!=0, a word when addr[1:0]!=0, and a doubleword when addr[2:0]!=0; misalignment yields fault 01.
REQ-013 funct3 values 011 and 110 with DATA_WIDTH=32, 111 on loads, and 011..111 on stores SHALL yield fault 11.
REQ-014 In REQ, mem_req_valid SHALL be 1 and all request fields SHALL stay stable until mem_req_ready=1; the request then completes, a store goes to HOLD, and a load goes to WAIT_RSP.
REQ-015 Store data SHALL be replicated per lane: a byte write sets be bit addr[k-1:0], a halfword sets two bits and a word sets four bits, where k = log2(DATA_WIDTH/8).
REQ-016 In WAIT_RSP, on mem_rsp_valid=1 the block SHALL select the addressed lane and sign-extend (LB, LH, LW) or zero-extend (LBU, LHU, LWU) it to DATA_WIDTH, register the result to out_load_data, and go to HOLD.
REQ-017 A wait counter SHALL increment each cycle in WAIT_RSP; if it reaches MAX_WAIT without a response, the block SHALL go to HOLD with fault 10 and out_load_data=0, and any late response SHALL be ignored.
REQ-018 In HOLD, out_valid SHALL be 1 and the outputs SHALL be stable; when out_ready=1 the block SHALL return to IDLE (no same-cycle accept, so maximum throughput is one operation per 2 cycles).
REQ-019 A mem_rsp_valid outside WAIT_RSP SHALL be ignored.
REQ-020 out_alu_result and out_meta SHALL equal the latched in_addr and in_meta for every operation, including faulting ones.

Reset
REQ-021 When reset is asserted the block SHALL, asynchronously, go to IDLE and clear in_ready, mem_req_valid, mem_req_we, mem_req_be, out_valid, out_fault, out_load_data and the wait counter to 0; in_ready rises on the first clock after deassertion.
REQ-022 A reset asserted mid-operation (REQ or WAIT_RSP) SHALL abandon the operation with no output produced, and the block SHALL ignore any later response.

Verification
REQ-023 LB with addr=0x1003 and rsp=0x80FF_FF00 -> be unused, req addr 0x1000, out_load_data 0xFFFF_FF80, fault 00.
REQ-024 SH with addr=0x2002 and wdata=0x0000_BEEF -> mem_req_be 1100, mem_req_wdata 0xBEEF_BEEF, no WAIT_RSP, out_valid after ready.
REQ-025 LW with addr=0x3001 -> no mem_req_valid, next-cycle out_valid, fault 01.
REQ-026 LW with mem_req_ready held low for 4 cycles -> request fields are stable for all 4 cycles, and mem_rsp_valid with no response for MAX_WAIT=15 cycles -> fault 10, out_load_data 0.
REQ-027 With DATA_WIDTH=64, LWU at addr 0x4004 with rsp=0xDEAD_BEEF_0000_0001 -> out 0x0000_0000_DEAD_BEEF.
REQ-028 Reset asserted while in WAIT_RSP, then a response arrives -> out_valid stays 0, in_ready=1 one cycle after reset deasserts.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between execute and writeback: aligns requests, steers byte lanes,
// extends load data and reports misaligned, timeout and illegal-funct3 faults.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int META_WIDTH = 48,
  parameter int MAX_WAIT   = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_addr,
  input  logic [DATA_WIDTH-1:0]   in_wdata,
  input  logic [2:0]              in_funct3,
  input  logic                    in_mem_read,
  input  logic                    in_mem_write,
  input  logic [META_WIDTH-1:0]   in_meta,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_we,
  output logic [31:0]             mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_be,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_load_data,
  output logic [31:0]             out_alu_result,
  output logic [META_WIDTH-1:0]   out_meta,
  output logic [1:0]              out_fault
);

  // state    | meaning
  // IDLE     | ready for a new operation
  // REQ      | memory request presented, waiting for mem_req_ready
  // WAIT_RSP | load issued, waiting for mem_rsp_valid or timeout
  // HOLD     | result presented on out_*, waiting for out_ready
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, HOLD} state_t;

  localparam int NB = DATA_WIDTH / 8;
  localparam int K  = $clog2(NB);
  localparam int CW = $clog2(MAX_WAIT + 1);

  state_t                  state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic [31:0]             addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]           be_q, be_d;
  logic                    we_q, we_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [META_WIDTH-1:0]   meta_q, meta_d;
  logic [DATA_WIDTH-1:0]   load_q, load_d;
  logic [1:0]              fault_q, fault_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic                    is_mem, misal, illegal;
  logic [1:0]              fault_in;
  logic [K-1:0]            in_off;
  logic [DATA_WIDTH-1:0]   wdata_fmt;
  logic [NB-1:0]           be_fmt;
  logic [DATA_WIDTH-1:0]   rsp_sh, rsp_ext;

  always_comb begin
    is_mem = in_mem_read | in_mem_write;
    in_off = in_addr[K-1:0];
    case (in_funct3[1:0])
      2'b01:   misal = in_addr[0];
      2'b10:   misal = |in_addr[1:0];
      2'b11:   misal = |in_addr[2:0];
      default: misal = 1'b0;
    endcase
    // a cycle with both strobes set is treated as a load
    if (in_mem_read)
      illegal = (in_funct3 == 3'b111) ||
                ((DATA_WIDTH == 32) && ((in_funct3 == 3'b011) || (in_funct3 == 3'b110)));
    else
      illegal = in_funct3 >= 3'b011;
    if (!is_mem)      fault_in = 2'b00;
    else if (illegal) fault_in = 2'b11;
    else if (misal)   fault_in = 2'b01;
    else              fault_in = 2'b00;

    case (in_funct3[1:0])
      2'b00: begin
        wdata_fmt = {NB{in_wdata[7:0]}};
        be_fmt    = NB'(1) << in_off;
      end
      2'b01: begin
        wdata_fmt = {(NB/2){in_wdata[15:0]}};
        be_fmt    = NB'(3) << in_off;
      end
      2'b10: begin
        wdata_fmt = {(NB/4){in_wdata[31:0]}};
        be_fmt    = NB'(15) << in_off;
      end
      default: begin
        wdata_fmt = in_wdata;
        be_fmt    = '1;
      end
    endcase

    rsp_sh = mem_rsp_rdata >> {addr_q[K-1:0], 3'b000};
    case (funct3_q)
      3'b000:  rsp_ext = DATA_WIDTH'($signed(rsp_sh[7:0]));
      3'b001:  rsp_ext = DATA_WIDTH'($signed(rsp_sh[15:0]));
      3'b010:  rsp_ext = DATA_WIDTH'($signed(rsp_sh[31:0]));
      3'b100:  rsp_ext = DATA_WIDTH'(rsp_sh[7:0]);
      3'b101:  rsp_ext = DATA_WIDTH'(rsp_sh[15:0]);
      3'b110:  rsp_ext = DATA_WIDTH'(rsp_sh[31:0]);
      default: rsp_ext = rsp_sh;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    meta_d   = meta_q;
    load_d   = load_q;
    fault_d  = fault_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          addr_d   = in_addr;
          meta_d   = in_meta;
          funct3_d = in_funct3;
          load_d   = '0;
          cnt_d    = '0;
          fault_d  = fault_in;
          if (is_mem && (fault_in == 2'b00)) begin
            we_d    = ~in_mem_read;
            wdata_d = wdata_fmt;
            be_d    = be_fmt;
            state_d = REQ;
          end else begin
            we_d    = 1'b0;
            be_d    = '0;
            state_d = HOLD;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = we_q ? HOLD : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          load_d  = rsp_ext;
          state_d = HOLD;
        end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
          fault_d = 2'b10;
          load_d  = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // registered so in_ready stays low through reset and rises one clock later
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      meta_q     <= '0;
      load_q     <= '0;
      fault_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      meta_q     <= meta_d;
      load_q     <= load_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign mem_req_valid  = (state_q == REQ);
  assign mem_req_we     = we_q;
  assign mem_req_addr   = addr_q & ~32'(NB - 1);
  assign mem_req_wdata  = wdata_q;
  assign mem_req_be     = be_q;
  assign out_valid      = (state_q == HOLD);
  assign out_load_data  = load_q;
  assign out_alu_result = addr_q;
  assign out_meta       = meta_q;
  assign out_fault      = fault_q;

endmodule
